// File: rtl/dut_dff.sv
// 4-bit capture register with synchronous active-low clear and side-band status.
// Optional saturating change counter upd_cnt is built when DUT_DFF_UPDCNT_EN is defined.
module dut_dff #(
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             q_valid,
  output logic             q_changed,
  output logic             q_parity
`ifdef DUT_DFF_UPDCNT_EN
  ,
  output logic [7:0]       upd_cnt
`endif
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             changed_q, changed_d;
  logic             differs;

  assign differs = (D != q_q);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    q_d       = D;
    valid_d   = 1'b1;
    changed_d = differs;
    if (!rst) begin
      q_d       = RESET_VAL;
      valid_d   = 1'b0;
      changed_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is sampled on the edge.
  always_ff @(posedge clk) begin
    q_q       <= q_d;
    valid_q   <= valid_d;
    changed_q <= changed_d;
  end

  assign Q         = q_q;
  assign q_valid   = valid_q;
  assign q_changed = changed_q;
  assign q_parity  = ^q_q;

`ifdef DUT_DFF_UPDCNT_EN
  logic [7:0] cnt_q, cnt_d;

  // Counts edges that actually change Q, sticking at 255.
  always_comb begin
    cnt_d = cnt_q;
    if (!rst) begin
      cnt_d = 8'h00;
    end else if (differs && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign upd_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_dut_dff.sv
// Self-checking bench for dut_dff: directed vectors with literal expectations,
// plus a behavioural model compared against the DUT on every falling edge.
module tb_dut_dff;

  logic       clk;
  logic       rst;
  logic [3:0] D;
  logic [3:0] Q;
  logic       q_valid, q_changed, q_parity;
`ifdef DUT_DFF_UPDCNT_EN
  logic [7:0] upd_cnt;
`endif

  int errors = 0;
  int checks = 0;

  dut_dff #(.WIDTH(4), .RESET_VAL(4'h0)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .D        (D),
    .Q        (Q),
    .q_valid  (q_valid),
    .q_changed(q_changed),
    .q_parity (q_parity)
`ifdef DUT_DFF_UPDCNT_EN
    ,
    .upd_cnt  (upd_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: Q is whatever D was at the last edge, or 0 if that edge was a reset.
  logic [3:0] m_q;
  logic       m_valid, m_changed, m_known;
  int         m_cnt;
  initial begin
    m_known = 1'b0;
    m_q = 'x; m_valid = 1'b0; m_changed = 1'b0; m_cnt = 0;
  end

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      m_q = 4'h0; m_valid = 1'b0; m_changed = 1'b0; m_cnt = 0;
      m_known = 1'b1;
    end else begin
      m_changed = (D !== m_q);
      if (m_changed && m_cnt < 255) m_cnt = m_cnt + 1;
      m_q = D;
      m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("model_q", 32'(Q), 32'(m_q));
      check("model_valid", 32'(q_valid), 32'(m_valid));
      check("model_changed", 32'(q_changed), 32'(m_changed));
      check("model_parity", 32'(q_parity), 32'(^m_q));
`ifdef DUT_DFF_UPDCNT_EN
      check("model_cnt", 32'(upd_cnt), 32'(m_cnt));
`endif
    end
  end

  // Drive on the falling edge, return 1 after the following rising edge.
  task automatic step(input logic [3:0] d, input logic r);
    @(negedge clk);
    D = d; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; D = 4'hF;
    @(posedge clk); #1;
    step(4'hF, 1'b0);
    check("rst_q", 32'(Q), 32'h0);
    check("rst_valid", 32'(q_valid), 32'h0);
    check("rst_parity", 32'(q_parity), 32'h0);
    check("rst_changed", 32'(q_changed), 32'h0);

    step(4'hA, 1'b1);
    check("cap_a_q", 32'(Q), 32'hA);
    check("cap_a_valid", 32'(q_valid), 32'h1);
    check("cap_a_changed", 32'(q_changed), 32'h1);
    check("cap_a_parity", 32'(q_parity), 32'h0);
    step(4'h5, 1'b1);
    check("cap_5_q", 32'(Q), 32'h5);
    check("cap_5_changed", 32'(q_changed), 32'h1);
    step(4'h3, 1'b1);
    check("cap_3_q", 32'(Q), 32'h3);
    check("cap_3_parity", 32'(q_parity), 32'h0);

    for (int i = 0; i < 3; i++) begin
      step(4'h3, 1'b1);
      check("hold_q", 32'(Q), 32'h3);
      check("hold_changed", 32'(q_changed), 32'h0);
`ifdef DUT_DFF_UPDCNT_EN
      check("hold_cnt", 32'(upd_cnt), 32'd3);
`endif
    end

    step(4'h9, 1'b1);
    check("pre_rst_q", 32'(Q), 32'h9);
    @(negedge clk);
    D = 4'h6; rst = 1'b0;
    #1;
    check("rst_pending_q", 32'(Q), 32'h9);
    @(posedge clk); #1;
    check("mid_rst_q", 32'(Q), 32'h0);
    check("mid_rst_valid", 32'(q_valid), 32'h0);
    step(4'h6, 1'b1);
    check("release_q", 32'(Q), 32'h6);
    check("release_valid", 32'(q_valid), 32'h1);
    check("release_changed", 32'(q_changed), 32'h1);

    step(4'h7, 1'b1);
    check("odd_parity", 32'(q_parity), 32'h1);

    for (int i = 0; i < 1000; i++) step(4'($urandom_range(0, 15)), 1'b1);

    step(4'h0, 1'b0);
    for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 4'h1 : 4'h2, 1'b1);
    check("alt_q", 32'(Q), 32'h2);
`ifdef DUT_DFF_UPDCNT_EN
    check("cnt_sat", 32'(upd_cnt), 32'hFF);
`endif
    step(4'h1, 1'b0);
    check("final_rst_q", 32'(Q), 32'h0);
`ifdef DUT_DFF_UPDCNT_EN
    check("cnt_clear", 32'(upd_cnt), 32'h00);
`endif

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
